// File: rtl/axis_pkg.sv
// Shared definitions for the AXI-Stream packet FIFO.
//   AXIS_*_WIDTH : default stream widths (512-bit data, 64 byte enables, 1 user bit)
//   wr_state_t   : write-side FSM state encoding
//   cnt32_t      : wrapping 32-bit statistics counter type
package axis_pkg;

    localparam int AXIS_DATA_WIDTH = 512;
    localparam int AXIS_KEEP_WIDTH = 64;
    localparam int AXIS_USER_WIDTH = 1;

    typedef enum logic {
        ST_STORE = 1'b0,
        ST_DROP  = 1'b1
    } wr_state_t;

    typedef logic [31:0] cnt32_t;

endpackage

// File: rtl/axis_pkt_store_fwd_fifo_if.sv
// AXI-Stream bundle used on both sides of the packet FIFO.
//   master modport : drives tvalid/tdata/tkeep/tlast/tuser, receives tready
//   slave modport  : receives tvalid/tdata/tkeep/tlast/tuser, drives tready
interface axis_pkt_store_fwd_fifo_if
    import axis_pkg::*;
#(
    parameter int DATA_WIDTH = AXIS_DATA_WIDTH,
    parameter int KEEP_WIDTH = AXIS_KEEP_WIDTH,
    parameter int USER_WIDTH = AXIS_USER_WIDTH
);

    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic                  tlast;
    logic [USER_WIDTH-1:0] tuser;

    modport master (
        output tvalid, tdata, tkeep, tlast, tuser,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tkeep, tlast, tuser,
        output tready
    );

endinterface

// File: rtl/axis_sdp_ram.sv
// Simple dual-port RAM for the packet FIFO beat storage.
//   clk          : clock
//   we/waddr/wdata : write port
//   re/raddr     : read request; rdata is valid the cycle after re and holds
//                  its value while re is low
// No reset on the array or the read register so the tools can map it to
// block or ultra RAM.
module axis_sdp_ram
    import axis_pkg::*;
#(
    parameter int DEPTH = 128,
    parameter int WIDTH = AXIS_DATA_WIDTH + AXIS_KEEP_WIDTH + AXIS_USER_WIDTH + 1
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/axis_pkt_store_fwd_fifo.sv
// Store-and-forward AXI-Stream packet FIFO (UDP TX stream -> CMAC TX).
// A packet becomes visible to the read side only once its tlast beat is
// stored, so the downstream MAC never sees a gap inside a frame. Packets
// longer than MAX_PKT_BEATS are discarded.
//
// Ports
//   clk, rst_n      : clock, asynchronous active-low reset
//   s_axis (slave)  : upstream stream in
//   m_axis (master) : downstream stream out
//   pkt_fwd_count   : packets fully sent on m_axis (wraps)
//   pkt_drop_count  : packets discarded (wraps)
//
// Build option AXIS_PKT_FIFO_ERR_DROP_EN: when defined, a packet whose tlast
// beat carries tuser[0] = 1 is discarded instead of committed. When undefined,
// tuser passes through per beat untouched.
//
// Write FSM
//   state    | meaning
//   ST_STORE | writing beats of the current packet into the RAM
//   ST_DROP  | oversize packet seen; swallowing beats up to its tlast
module axis_pkt_store_fwd_fifo
    import axis_pkg::*;
#(
    parameter int DATA_WIDTH    = AXIS_DATA_WIDTH,
    parameter int KEEP_WIDTH    = AXIS_KEEP_WIDTH,
    parameter int USER_WIDTH    = AXIS_USER_WIDTH,
    parameter int DEPTH         = 128,
    parameter int MAX_PKT_BEATS = 128
) (
    input  logic                     clk,
    input  logic                     rst_n,
    axis_pkt_store_fwd_fifo_if.slave  s_axis,
    axis_pkt_store_fwd_fifo_if.master m_axis,
    output cnt32_t                   pkt_fwd_count,
    output cnt32_t                   pkt_drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(MAX_PKT_BEATS + 1);
    localparam int RW = DATA_WIDTH + KEEP_WIDTH + USER_WIDTH + 1;

    wr_state_t     state;
    wr_state_t     state_nxt;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] commit_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] occupancy;
    logic [CW-1:0] beat_cnt;
    logic          live;
    logic          s_fire;
    logic          m_fire;
    logic          store_beat;
    logic          pkt_commit;
    logic          pkt_abort;
    logic          oversize;
    logic          err_flag;
    logic          rd_en;
    logic          m_valid_q;
    logic          last_raw;
    logic [RW-1:0] wr_word;
    logic [RW-1:0] rd_word;

    assign occupancy = wr_ptr - rd_ptr;
    assign s_fire    = s_axis.tvalid & s_axis.tready;
    assign m_fire    = m_valid_q & m_axis.tready;

`ifdef AXIS_PKT_FIFO_ERR_DROP_EN
    assign err_flag = s_axis.tuser[0];
`else
    assign err_flag = 1'b0;
`endif

    // Holds tready low while reset is asserted and for the first edge after.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live <= 1'b0;
        end else begin
            live <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_STORE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_STORE: if (oversize) state_nxt = ST_DROP;
            ST_DROP:  if (s_fire && s_axis.tlast) state_nxt = ST_STORE;
            default:  state_nxt = ST_STORE;
        endcase
    end

    always_comb begin
        s_axis.tready = 1'b0;
        store_beat    = 1'b0;
        pkt_commit    = 1'b0;
        pkt_abort     = 1'b0;
        oversize      = 1'b0;
        case (state)
            ST_STORE: begin
                s_axis.tready = live && (occupancy < PW'(DEPTH));
                store_beat    = s_fire;
                if (s_fire && s_axis.tlast) begin
                    pkt_commit = !err_flag;
                    pkt_abort  = err_flag;
                end else if (s_fire && (beat_cnt == CW'(MAX_PKT_BEATS - 1))) begin
                    // This non-last beat would be beat MAX_PKT_BEATS: too long.
                    oversize  = 1'b1;
                    pkt_abort = 1'b1;
                end
            end
            ST_DROP: begin
                s_axis.tready = live;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr         <= '0;
            commit_ptr     <= '0;
            beat_cnt       <= '0;
            pkt_drop_count <= '0;
        end else if (store_beat) begin
            // Aborted beats are still written; rewinding wr_ptr makes them free space.
            wr_ptr <= pkt_abort ? commit_ptr : wr_ptr + PW'(1);
            if (pkt_commit) begin
                commit_ptr <= wr_ptr + PW'(1);
            end
            if (s_axis.tlast || pkt_abort) begin
                beat_cnt <= '0;
            end else begin
                beat_cnt <= beat_cnt + CW'(1);
            end
            if (pkt_abort) begin
                pkt_drop_count <= pkt_drop_count + 32'd1;
            end
        end
    end

    // Read only committed beats, and only when the output slot frees this cycle.
    assign rd_en = (rd_ptr != commit_ptr) && (!m_valid_q || m_axis.tready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr        <= '0;
            m_valid_q     <= 1'b0;
            pkt_fwd_count <= '0;
        end else begin
            if (rd_en) begin
                rd_ptr    <= rd_ptr + PW'(1);
                m_valid_q <= 1'b1;
            end else if (m_fire) begin
                m_valid_q <= 1'b0;
            end
            if (m_fire && last_raw) begin
                pkt_fwd_count <= pkt_fwd_count + 32'd1;
            end
        end
    end

    assign wr_word = {s_axis.tuser, s_axis.tkeep, s_axis.tdata, s_axis.tlast};

    // The RAM read register doubles as the output register: it only changes
    // on rd_en, so payload is held while the sink stalls.
    axis_sdp_ram #(
        .DEPTH (DEPTH),
        .WIDTH (RW)
    ) u_ram (
        .clk   (clk),
        .we    (store_beat),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (wr_word),
        .re    (rd_en),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (rd_word)
    );

    assign {m_axis.tuser, m_axis.tkeep, m_axis.tdata, last_raw} = rd_word;
    assign m_axis.tvalid = m_valid_q;
    assign m_axis.tlast  = m_valid_q & last_raw;

endmodule
